// File: rtl/ascii_seg7_ca_demo_if.sv
// Display-side bundle for the ASCII 7-segment demo.
// Segment/point/anode lines are active-low.
interface ascii_seg7_ca_demo_if;
  logic [6:0] segments;
  logic       dp;
  logic       sel7;
  logic [6:0] ascii_code;

  modport master (
    output segments,
    output dp,
    output sel7,
    output ascii_code
  );

  modport slave (
    input segments,
    input dp,
    input sel7,
    input ascii_code
  );
endinterface

// File: rtl/ascii_seg7_ca_demo.sv
// Self-running ASCII walker for one common-anode digit.
// Define ASCII_SEG7_DP_LSB_EN to light the point on odd codes.
module ascii_seg7_ca_demo #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int STEP_HZ = 2,
  parameter int DIV     = CLK_HZ / STEP_HZ
) (
  input  logic clk,
  input  logic rst_n,
  ascii_seg7_ca_demo_if.master disp
);

  localparam int PW = $clog2(DIV);

  logic [PW-1:0] pre;
  logic          step;
  logic [6:0]    code;
  logic [6:0]    ch;
  logic [6:0]    pat;
  logic [6:0]    seg_q;
  logic          sel_q;

  assign step = (pre == PW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre  <= '0;
      code <= 7'h00;
    end else if (step) begin
      pre  <= '0;
      code <= code + 7'd1;
    end else begin
      pre  <= pre + PW'(1);
    end
  end

  // lower-case letters fold onto upper-case
  always_comb begin
    ch = code;
    if (code >= 7'h61 && code <= 7'h7A)
      ch = code & 7'h5F;
  end

  always_comb begin
    pat = 7'h00;
    case (ch)
      7'h30: pat = 7'h3F;
      7'h31: pat = 7'h06;
      7'h32: pat = 7'h5B;
      7'h33: pat = 7'h4F;
      7'h34: pat = 7'h66;
      7'h35: pat = 7'h6D;
      7'h36: pat = 7'h7D;
      7'h37: pat = 7'h07;
      7'h38: pat = 7'h7F;
      7'h39: pat = 7'h6F;
      7'h41: pat = 7'h77;
      7'h42: pat = 7'h7C;
      7'h43: pat = 7'h39;
      7'h44: pat = 7'h5E;
      7'h45: pat = 7'h79;
      7'h46: pat = 7'h71;
      7'h47: pat = 7'h3D;
      7'h48: pat = 7'h76;
      7'h49: pat = 7'h30;
      7'h4A: pat = 7'h1E;
      7'h4C: pat = 7'h38;
      7'h4E: pat = 7'h54;
      7'h4F: pat = 7'h3F;
      7'h50: pat = 7'h73;
      7'h51: pat = 7'h67;
      7'h52: pat = 7'h50;
      7'h53: pat = 7'h6D;
      7'h54: pat = 7'h78;
      7'h55: pat = 7'h3E;
      7'h59: pat = 7'h6E;
      7'h5A: pat = 7'h5B;
      7'h2D: pat = 7'h40;
      7'h5F: pat = 7'h08;
      7'h3D: pat = 7'h48;
      default: pat = 7'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= 7'h7F;
      sel_q <= 1'b1;
    end else begin
      seg_q <= ~pat;
      sel_q <= 1'b0;
    end
  end

`ifdef ASCII_SEG7_DP_LSB_EN
  logic dp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dp_q <= 1'b1;
    else
      dp_q <= ~code[0];
  end

  assign disp.dp = dp_q;
`else
  assign disp.dp = 1'b1;
`endif

  assign disp.segments   = seg_q;
  assign disp.sel7       = sel_q;
  assign disp.ascii_code = code;

endmodule

// File: tb/tb_ascii_seg7_ca_demo.sv
// Bench for ascii_seg7_ca_demo with DIV=4.
// Expected display words are queued per clock and checked next edge.
module tb_ascii_seg7_ca_demo;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int errors = 0;
  int checks = 0;

  ascii_seg7_ca_demo_if disp ();

  ascii_seg7_ca_demo #(.DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .disp  (disp)
  );

  always #5 clk = ~clk;

  logic [7:0] sb [$];
  int         pre_m;
  logic [6:0] code_m;
  logic       seen_7f;

  function automatic logic [6:0] seg_of(input logic [6:0] c);
    byte u;
    logic [6:0] p;
    u = {1'b0, c};
    if (u >= "a" && u <= "z") u = u - 8'd32;
    p = 7'h00;
    case (u)
      "0": p = 7'h3F; "1": p = 7'h06;
      "2": p = 7'h5B; "3": p = 7'h4F;
      "4": p = 7'h66; "5": p = 7'h6D;
      "6": p = 7'h7D; "7": p = 7'h07;
      "8": p = 7'h7F; "9": p = 7'h6F;
      "A": p = 7'h77; "B": p = 7'h7C;
      "C": p = 7'h39; "D": p = 7'h5E;
      "E": p = 7'h79; "F": p = 7'h71;
      "G": p = 7'h3D; "H": p = 7'h76;
      "I": p = 7'h30; "J": p = 7'h1E;
      "L": p = 7'h38; "N": p = 7'h54;
      "O": p = 7'h3F; "P": p = 7'h73;
      "Q": p = 7'h67; "R": p = 7'h50;
      "S": p = 7'h6D; "T": p = 7'h78;
      "U": p = 7'h3E; "Y": p = 7'h6E;
      "Z": p = 7'h5B; "-": p = 7'h40;
      "_": p = 7'h08; "=": p = 7'h48;
      default: p = 7'h00;
    endcase
    return ~p;
  endfunction

  function automatic logic dp_of(input logic [6:0] c);
`ifdef ASCII_SEG7_DP_LSB_EN
    return ~c[0];
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    sb.push_back({dp_of(code_m), seg_of(code_m)});
    if (pre_m == DIV - 1) begin
      pre_m  = 0;
      code_m = code_m + 7'd1;
    end else begin
      pre_m = pre_m + 1;
    end
    @(negedge clk);
    e = sb.pop_front();
    chk("segments", 32'(disp.segments), 32'(e[6:0]));
    chk("dp", 32'(disp.dp), 32'(e[7]));
    chk("ascii_code", 32'(disp.ascii_code), 32'(code_m));
    chk("sel7", 32'(disp.sel7), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_seg"}, 32'(disp.segments), 32'h7F);
    chk({tag, "_dp"}, 32'(disp.dp), 32'd1);
    chk({tag, "_sel7"}, 32'(disp.sel7), 32'd1);
    chk({tag, "_code"}, 32'(disp.ascii_code), 32'd0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n  = 1'b1;
    pre_m  = 0;
    code_m = 7'h00;
    sb.delete();
  endtask

  initial begin
    seen_7f = 1'b0;
    pre_m   = 0;
    code_m  = 7'h00;

    #100;
    chk_reset("por");
    release_rst();

    // first step lands exactly DIV clocks after release
    for (int i = 0; i < DIV - 1; i++) tick();
    chk("pre_step", 32'(disp.ascii_code), 32'd0);
    tick();
    chk("first_step", 32'(disp.ascii_code), 32'd1);

    for (int i = 0; i < 9; i++) tick();

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("async");
    #20;
    chk_reset("held");
    release_rst();

    for (int i = 0; i < DIV - 1; i++) tick();
    chk("restart_hold", 32'(disp.ascii_code), 32'd0);

    for (int i = 0; i < 128 * DIV + 2 * DIV; i++) begin
      tick();
      if (disp.ascii_code == 7'h7F) seen_7f = 1'b1;
    end
    chk("saw_7f", 32'(seen_7f), 32'd1);
    chk("after_wrap", 32'(disp.ascii_code), 32'(code_m));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
